sdram_init_seq: RTL and testbench
=================================

# sdram_init_seq

SDRAM power-up initialization sequencer, in the 100 MHz SDRAM clock domain directly downstream of the clock/reset generator. It runs the JEDEC power-up sequence once reset releases: stable-clock wait, PRECHARGE ALL, N AUTO REFRESH, LOAD MODE REGISTER. While the sequence runs it drives the SDRAM command/address pins. It then raises `init_done` so the SDRAM controller can take the bus. A re-init request lets the controller rerun the command part after suspend without repeating the power-up wait.

## Interface
- `CLK_FREQ_MHZ`, 100, clock frequency in MHz; scales the power-up wait.
- `T_POWERUP_US`, 200, power-up wait in µs. W = `T_POWERUP_US*CLK_FREQ_MHZ` cycles (20000 at defaults).
- `T_RP`, 2, PRECHARGE-to-command cycles; must be ≥1.
- `T_RFC`, 7, REFRESH-to-command cycles; must be ≥1.
- `T_MRD`, 2, LOAD MODE-to-done cycles; must be ≥1.
- `N_REFRESH`, 8, AUTO REFRESH count; range 1..15.
- `MODE_REG`, 13'h0032, mode register value (CAS 3, burst 4, sequential).

Ports:
- `clk` input 1: SDRAM clock (`clk_100m`).
- `rst` input 1: synchronous, active-high reset. Top level drives it from inverted `sdram_rst_n`, synchronized to `clk`.
- `reinit_req` input 1: pulse; request re-initialization. Honoured only in DONE.
- `sdram_cke` output 1: clock enable.
- `sdram_cmd` output 4: {cs_n, ras_n, cas_n, we_n}.
- `sdram_addr` output 13: address bus.
- `sdram_ba` output 2: bank address.
- `init_done` output 1: sequence complete; controller owns the bus.

## Operation
- Command encodings:
  - INHIBIT = 4'b1111
  - NOP = 4'b0111
  - PRECHARGE = 4'b0010
  - AUTO REFRESH = 4'b0001
  - LOAD MODE = 4'b0000
- All outputs are registered.
- Reset values: `sdram_cke`=0, `sdram_cmd`=INHIBIT, `sdram_addr`=0, `sdram_ba`=0, `init_done`=0, state=WAIT, counters=0.
- WAIT: `sdram_cke`=1 and cmd NOP for W cycles, then go to PRE.
- PRE: one PRECHARGE cycle with `addr[10]`=1 (all banks), other addr bits 0, ba=0. Go to PRE_WAIT.
- PRE_WAIT: NOP for T_RP−1 cycles, then go to REF.
- REF: one AUTO REFRESH cycle; increment the refresh count. Go to REF_WAIT.
- REF_WAIT: NOP for T_RFC−1 cycles. If count < N_REFRESH go to REF, else go to MRS.
- MRS: one LOAD MODE cycle with addr=MODE_REG, ba=0. Go to MRS_WAIT.
- MRS_WAIT: NOP for T_MRD−1 cycles, then go to DONE.
- DONE: `init_done`=1 and cmd NOP. Stays here until `rst` or `reinit_req`.
- Outside the command cycles, addr and ba are 0.
- `reinit_req` in DONE:
  - The next cycle `init_done` drops to 0 and state enters PRE. The power-up wait is skipped and `sdram_cke` stays 1.
  - The refresh count is cleared.
  - `reinit_req` in any other state is ignored; it is not queued.
- `rst` mid-sequence: on the next edge all outputs return to reset values and the sequence restarts at WAIT with a full W wait.
- The wait counter is `$clog2(W+1)` bits wide and never wraps. The refresh counter is 4 bits.

## Timing
- Cycle k is the output interval after the k-th rising edge with `rst`=0 (k ≥ 1).
- Cycles 1..W: `sdram_cke`=1, cmd NOP.
- Cycle W+1: PRECHARGE.
- Refresh i (i = 0..N_REFRESH−1) at cycle W+T_RP+1+i·T_RFC.
- LOAD MODE at cycle W+T_RP+N_REFRESH·T_RFC+1.
- `init_done`=1 from cycle W+T_RP+N_REFRESH·T_RFC+T_MRD+1.
- Defaults: PRECHARGE at 20001; refreshes at 20003, 20010, …, 20052; LOAD MODE at 20059; `init_done` at 20061.
- Re-init: `reinit_req` sampled high at edge j (state DONE) gives `init_done`=0 from j. PRECHARGE is issued in that interval. LOAD MODE follows T_RP+N_REFRESH·T_RFC cycles later, and `init_done` returns T_MRD cycles after LOAD MODE (61 cycles total at defaults).
- `rst` and `reinit_req` in the same cycle: `rst` wins.

## Configuration
- `SDRAM_INIT_FAST_SIM_EN`:
  - Defined: W is forced to 64 cycles regardless of `T_POWERUP_US`, for simulation. Defaults then give PRECHARGE at 65, LOAD MODE at 123, `init_done` at 125.
  - Undefined: W = `T_POWERUP_US*CLK_FREQ_MHZ`.

## Test plan
- Fast-sim defaults, release `rst` → PRECHARGE at cycle 65 with addr=13'h0400. 8 REFRESH at 67 + 7i. LOAD MODE at 123 with addr=13'h0032. `init_done`=1 at 125. NOP in every other cycle.
- During `rst`=1 → `sdram_cke`=0, cmd=4'b1111, addr=0, `init_done`=0. `sdram_cke`=1 from cycle 1 after release.
- Assert `rst` at cycle 90 (mid-refresh) → reset values next cycle. After release, PRECHARGE again at cycle 65 relative to the new release.
- `reinit_req` pulse at cycle 200 (DONE) → `init_done`=0 and PRECHARGE in cycle 201. `sdram_cke` stays 1. `init_done`=1 again 61 cycles later.
- `reinit_req` pulse at cycle 30 (WAIT) → ignored. Timeline identical to the first scenario.
- `N_REFRESH`=1, `T_RFC`=1, `T_RP`=1, `T_MRD`=1 → PRECHARGE at 65, REFRESH at 66, LOAD MODE at 67, `init_done` at 68.

Source files
------------

// File: rtl/sdram_init_if.sv
// SDRAM init sequencer bus: command/address pins towards the SDRAM, plus the
// re-init request and completion flag exchanged with the SDRAM controller.
interface sdram_init_if;
    logic        reinit_req;
    logic        sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_ba;
    logic        init_done;

    modport master (
        input  reinit_req,
        output sdram_cke, sdram_cmd, sdram_addr, sdram_ba, init_done
    );
    modport slave (
        output reinit_req,
        input  sdram_cke, sdram_cmd, sdram_addr, sdram_ba, init_done
    );
endinterface

// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer: wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE, done.
// Optional feature macro SDRAM_INIT_FAST_SIM_EN shortens the power-up wait to 64 cycles.
module sdram_init_seq #(
    parameter int          CLK_FREQ_MHZ = 100,
    parameter int          T_POWERUP_US = 200,
    parameter int          T_RP         = 2,
    parameter int          T_RFC        = 7,
    parameter int          T_MRD        = 2,
    parameter int          N_REFRESH    = 8,
    parameter logic [12:0] MODE_REG     = 13'h0032
) (
    input  logic          clk,
    input  logic          rst,
    sdram_init_if.master  bus
);
`ifdef SDRAM_INIT_FAST_SIM_EN
    localparam int W = 64;
`else
    localparam int W = T_POWERUP_US * CLK_FREQ_MHZ;
`endif
    localparam int CW = $clog2(W + 1);

    localparam logic [CW-1:0] W_C    = CW'(W);
    localparam logic [CW-1:0] RP_M1  = CW'(T_RP - 1);
    localparam logic [CW-1:0] RFC_M1 = CW'(T_RFC - 1);
    localparam logic [CW-1:0] MRD_M1 = CW'(T_MRD - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [3:0]    N_C    = 4'(N_REFRESH);

    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_LMR     = 4'b0000;

    typedef enum logic [2:0] {
        S_WAIT, S_PRE, S_PRE_WAIT, S_REF, S_REF_WAIT, S_MRS, S_MRS_WAIT, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic [3:0]      ref_q, ref_d;
    logic            cke_q, done_q;
    logic [3:0]      cmd_q;
    logic [12:0]     addr_q;
    logic [1:0]      ba_q;

    // state_q names the command interval currently on the pins; each wait state
    // counts the NOP cycles already emitted since its command.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ref_d   = ref_q;
        case (state_q)
            S_WAIT: begin
                if (wait_q < W_C) begin
                    wait_d = wait_q + ONE;
                end else begin
                    state_d = S_PRE;
                    wait_d  = '0;
                end
            end
            S_PRE, S_PRE_WAIT: begin
                if (state_q == S_PRE && T_RP > 1) begin
                    state_d = S_PRE_WAIT;
                    wait_d  = ONE;
                end else if (state_q == S_PRE_WAIT && wait_q < RP_M1) begin
                    wait_d = wait_q + ONE;
                end else begin
                    state_d = S_REF;
                    wait_d  = '0;
                    ref_d   = ref_q + 4'd1;
                end
            end
            S_REF, S_REF_WAIT: begin
                if (state_q == S_REF && T_RFC > 1) begin
                    state_d = S_REF_WAIT;
                    wait_d  = ONE;
                end else if (state_q == S_REF_WAIT && wait_q < RFC_M1) begin
                    wait_d = wait_q + ONE;
                end else if (ref_q < N_C) begin
                    state_d = S_REF;
                    wait_d  = '0;
                    ref_d   = ref_q + 4'd1;
                end else begin
                    state_d = S_MRS;
                    wait_d  = '0;
                end
            end
            S_MRS, S_MRS_WAIT: begin
                if (state_q == S_MRS && T_MRD > 1) begin
                    state_d = S_MRS_WAIT;
                    wait_d  = ONE;
                end else if (state_q == S_MRS_WAIT && wait_q < MRD_M1) begin
                    wait_d = wait_q + ONE;
                end else begin
                    state_d = S_DONE;
                    wait_d  = '0;
                end
            end
            S_DONE: begin
                // Re-init skips the power-up wait and starts at PRECHARGE.
                if (bus.reinit_req) begin
                    state_d = S_PRE;
                    wait_d  = '0;
                    ref_d   = '0;
                end
            end
            default: begin
                state_d = S_WAIT;
                wait_d  = '0;
                ref_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_WAIT;
            wait_q  <= '0;
            ref_q   <= '0;
            cke_q   <= 1'b0;
            cmd_q   <= CMD_INHIBIT;
            addr_q  <= '0;
            ba_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ref_q   <= ref_d;
            cke_q   <= 1'b1;
            ba_q    <= '0;
            done_q  <= (state_d == S_DONE);
            case (state_d)
                S_PRE: begin
                    cmd_q  <= CMD_PRE;
                    addr_q <= 13'h0400;
                end
                S_REF: begin
                    cmd_q  <= CMD_REF;
                    addr_q <= '0;
                end
                S_MRS: begin
                    cmd_q  <= CMD_LMR;
                    addr_q <= MODE_REG;
                end
                default: begin
                    cmd_q  <= CMD_NOP;
                    addr_q <= '0;
                end
            endcase
        end
    end

    assign bus.sdram_cke  = cke_q;
    assign bus.sdram_cmd  = cmd_q;
    assign bus.sdram_addr = addr_q;
    assign bus.sdram_ba   = ba_q;
    assign bus.init_done  = done_q;
endmodule

// File: tb/tb_sdram_init_seq.sv
// Directed bench for sdram_init_seq: event tables checked every cycle, plus
// reset, mid-sequence reset, re-init and ignored re-init sequences.
module tb_sdram_init_seq;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] LMR = 4'b0000;
    localparam logic [3:0] INH = 4'b1111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_init_if bus1();
    sdram_init_if bus2();

    // W = 1 MHz * 64 us = 64 cycles, same as the fast-sim build.
    sdram_init_seq #(.CLK_FREQ_MHZ(1), .T_POWERUP_US(64)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    sdram_init_seq #(.CLK_FREQ_MHZ(1), .T_POWERUP_US(64), .T_RP(1), .T_RFC(1),
                     .T_MRD(1), .N_REFRESH(1)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [12:0] addr;
    } ev_t;

    ev_t ev1[10];
    ev_t ev2[10];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    function automatic logic [20:0] exp_of(input ev_t t[10], input int k, input int off,
                                           input int done_at);
        logic [3:0]  c = NOP;
        logic [12:0] a = '0;
        for (int i = 0; i < 10; i++)
            if (t[i].cyc >= 0 && t[i].cyc + off == k) begin
                c = t[i].cmd;
                a = t[i].addr;
            end
        return {1'b1, c, a, 2'b00, (k >= done_at)};
    endfunction

    function automatic logic [20:0] act_of1();
        return {bus1.sdram_cke, bus1.sdram_cmd, bus1.sdram_addr, bus1.sdram_ba, bus1.init_done};
    endfunction

    function automatic logic [20:0] act_of2();
        return {bus2.sdram_cke, bus2.sdram_cmd, bus2.sdram_addr, bus2.sdram_ba, bus2.init_done};
    endfunction

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {cke,cmd,addr,ba,done}=%h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Hold rst for n edges, checking reset values on both DUTs, then release.
    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            check($sformatf("rst1_%0d", i), act_of1(), {1'b0, INH, 13'h0, 2'b00, 1'b0});
            check($sformatf("rst2_%0d", i), act_of2(), {1'b0, INH, 13'h0, 2'b00, 1'b0});
        end
        bus1.reinit_req = 1'b0;
        rst = 1'b0;
        cyc = 0;
    endtask

    // Step up to cycle 'last'; dut1 expects its table shifted by 'off',
    // reinit_req is driven high during cycle 'pulse'.
    task automatic run(input int last, input int off, input int pulse);
        while (cyc < last) begin
            step();
            check($sformatf("dut1_c%0d", cyc), act_of1(), exp_of(ev1, cyc, off, 125 + off));
            check($sformatf("dut2_c%0d", cyc), act_of2(), exp_of(ev2, cyc, 0, 68));
            bus1.reinit_req = (cyc == pulse);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ev1[0] = '{65, PRE, 13'h0400};
        for (int i = 0; i < 8; i++) ev1[1 + i] = '{67 + 7 * i, REF, 13'h0};
        ev1[9] = '{123, LMR, 13'h0032};
        for (int i = 0; i < 10; i++) ev2[i] = '{-1, NOP, 13'h0};
        ev2[0] = '{65, PRE, 13'h0400};
        ev2[1] = '{66, REF, 13'h0};
        ev2[2] = '{67, LMR, 13'h0032};
        bus1.reinit_req = 1'b0;
        bus2.reinit_req = 1'b0;

        // Power-up, full sequence, then re-init pulse in DONE at cycle 200.
        do_reset(3);
        run(200, 0, 200);
        run(270, 136, -1);

        // rst and reinit_req together in DONE: reset wins.
        bus1.reinit_req = 1'b1;
        do_reset(2);

        // Re-init in WAIT is ignored; rst mid-refresh at cycle 90.
        run(90, 0, 30);
        do_reset(1);

        // Fresh sequence after mid-run reset uses the full wait again.
        run(130, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
